// File: rtl/ps2_rx_scan.sv
`timescale 1ns/1ps
// PS/2 keyboard receiver: synchronises and debounces ps2clk/ps2data, deframes
// 11-bit frames and folds E0/F0 prefixes into a single scan-code strobe.
module ps2_rx_scan #(
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2clk,
    input  logic       ps2data,
    output logic [7:0] code,
    output logic       code_rel,
    output logic       code_ext,
    output logic       code_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [1:0] w_raw;
    logic [1:0] w_filt;
    logic       w_fclk;
    logic       w_fdat;
    logic       w_fall;
    logic       w_timeout;
    state_t     r_state;
    state_t     w_state_next;

    logic           r_fclk_d;
    logic [2:0]     r_bit_cnt;
    logic [7:0]     r_shift;
    logic           r_par;
    logic           r_done;
    logic           r_frame_ok;
    logic [TCW-1:0] r_to_cnt;
    logic           r_rel;
    logic           r_ext;
    logic [7:0]     r_code;
    logic           r_code_rel;
    logic           r_code_ext;
    logic           r_code_valid;
    logic           r_frame_err;

    assign w_raw = {ps2data, ps2clk};

    // Channel 0 is ps2clk, channel 1 is ps2data; a level is accepted only after
    // FILT_LEN consecutive synchronised samples disagree with the current one.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic           r_s1;
            logic           r_s2;
            logic           r_f;
            logic [FCW-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_s1  <= 1'b1;
                    r_s2  <= 1'b1;
                    r_f   <= 1'b1;
                    r_cnt <= '0;
                end else begin
                    r_s1 <= w_raw[gi];
                    r_s2 <= r_s1;
                    if (r_s2 == r_f) begin
                        r_cnt <= '0;
                    end else if (r_cnt == FCW'(FILT_LEN - 1)) begin
                        r_f   <= r_s2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_filt[gi] = r_f;
        end
    endgenerate

    assign w_fclk    = w_filt[0];
    assign w_fdat    = w_filt[1];
    assign w_fall    = r_fclk_d & ~w_fclk;
    assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_to_cnt == TCW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_fall && !w_fdat) w_state_next = S_DATA;
            S_DATA:   if (w_fall && (r_bit_cnt == 3'd7)) w_state_next = S_PARITY;
            S_PARITY: if (w_fall) w_state_next = S_STOP;
            S_STOP:   if (w_fall) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
        if (w_timeout) w_state_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fclk_d     <= 1'b1;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par        <= 1'b0;
            r_done       <= 1'b0;
            r_frame_ok   <= 1'b0;
            r_to_cnt     <= '0;
            r_rel        <= 1'b0;
            r_ext        <= 1'b0;
            r_code       <= '0;
            r_code_rel   <= 1'b0;
            r_code_ext   <= 1'b0;
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_fclk_d     <= w_fclk;
            r_done       <= 1'b0;
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;

            if (w_fall || (r_state == S_IDLE)) r_to_cnt <= '0;
            else r_to_cnt <= r_to_cnt + 1'b1;

            if (w_fall) begin
                case (r_state)
                    S_IDLE:   r_bit_cnt <= '0;
                    S_DATA: begin
                        r_shift   <= {w_fdat, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    S_PARITY: r_par <= w_fdat;
                    S_STOP: begin
                        r_done     <= 1'b1;
                        r_frame_ok <= w_fdat & (^{r_shift, r_par});
                    end
                    default: r_bit_cnt <= '0;
                endcase
            end

            // r_done only follows STOP->IDLE, so it can never coincide with a timeout.
            if (w_timeout) begin
                r_frame_err <= 1'b1;
                r_rel       <= 1'b0;
                r_ext       <= 1'b0;
            end else if (r_done) begin
                if (!r_frame_ok) begin
                    r_frame_err <= 1'b1;
                    r_rel       <= 1'b0;
                    r_ext       <= 1'b0;
                end else if (r_shift == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (r_shift == 8'hF0) begin
                    r_rel <= 1'b1;
                end else begin
                    r_code       <= r_shift;
                    r_code_rel   <= r_rel;
                    r_code_ext   <= r_ext;
                    r_code_valid <= 1'b1;
                    r_rel        <= 1'b0;
                    r_ext        <= 1'b0;
                end
            end
        end
    end

    assign code       = r_code;
    assign code_rel   = r_code_rel;
    assign code_ext   = r_code_ext;
    assign code_valid = r_code_valid;
    assign frame_err  = r_frame_err;
    assign rx_busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_ps2_rx_scan.sv
`timescale 1ns/1ps
// Randomised PS/2 frame stimulus against a byte-level reference model of the
// prefix/strobe rules; one line per frame, one summary line at the end.
module tb_ps2_rx_scan;

    localparam int FILT = 8;
    localparam int TO   = 5000;
    localparam int LAT_MAX = 2 + FILT + 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2clk = 1'b1;
    logic       ps2data = 1'b1;
    logic [7:0] code;
    logic       code_rel;
    logic       code_ext;
    logic       code_valid;
    logic       frame_err;
    logic       rx_busy;

    ps2_rx_scan #(.FILT_LEN(FILT), .TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2clk     (ps2clk),
        .ps2data    (ps2data),
        .code       (code),
        .code_rel   (code_rel),
        .code_ext   (code_ext),
        .code_valid (code_valid),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Event encoding: {kind[1:0], rel, ext, code[7:0]}; kind 1 = code, 2 = error.
    logic [11:0] obs_q[$];
    logic [11:0] exp_q[$];
    int last_valid_cyc = 0;
    int stop_fall_cyc  = 0;
    int both_cnt       = 0;
    bit exp_valid_last = 0;

    always @(negedge clk) begin
        if (code_valid) begin
            obs_q.push_back({2'd1, code_rel, code_ext, code});
            last_valid_cyc = cyc;
        end
        if (frame_err) obs_q.push_back({2'd2, 2'b00, 8'h00});
        if (code_valid && frame_err) both_cnt++;
    end

    // Reference model state: pending prefixes and the held output values.
    bit       m_rel = 0, m_ext = 0, m_crel = 0, m_cext = 0;
    logic [7:0] m_code = 8'h00;

    task automatic model_reset();
        m_rel = 0; m_ext = 0; m_crel = 0; m_cext = 0; m_code = 8'h00;
    endtask

    task automatic model_err();
        exp_q.push_back({2'd2, 2'b00, 8'h00});
        m_rel = 0; m_ext = 0;
    endtask

    task automatic model_frame(input logic [7:0] b, input bit ok, output bit v);
        v = 0;
        if (!ok) model_err();
        else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_rel = 1;
        else begin
            exp_q.push_back({2'd1, m_rel, m_ext, b});
            m_code = b; m_crel = m_rel; m_cext = m_ext;
            m_rel = 0; m_ext = 0;
            v = 1;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive_bit(input bit d, input int half, input bit glitch);
        ps2data = d;
        if (glitch) begin
            wait_cyc(half / 3);
            ps2clk = 1'b0;
            wait_cyc(3);
            ps2clk = 1'b1;
            wait_cyc(half - half / 3 - 3);
        end else begin
            wait_cyc(half);
        end
        ps2clk = 1'b0;
        stop_fall_cyc = cyc;
        wait_cyc(half);
        ps2clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int half, input bit glitch);
        logic [10:0] bits;
        logic        par;
        bit          v;
        par  = (~^b) ^ bad_par;
        bits = {~bad_stop, par, b, 1'b0};
        for (int i = 0; i < 11; i++) drive_bit(bits[i], half, glitch);
        ps2data = 1'b1;
        model_frame(b, !(bad_par || bad_stop), v);
        exp_valid_last = v;
        $display("frame byte=0x%02h bad_par=%0d bad_stop=%0d half=%0d glitch=%0d",
                 b, bad_par, bad_stop, half, glitch);
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits, input int half, input bit glitch);
        drive_bit(1'b0, half, glitch);
        for (int i = 0; i < nbits; i++) drive_bit(b[i], half, glitch);
        ps2data = 1'b1;
        $display("partial byte=0x%02h bits=%0d half=%0d glitch=%0d", b, nbits, half, glitch);
    endtask

    task automatic compare_events(input string tag);
        int lat;
        wait_cyc(LAT_MAX + 8);
        check_eq({tag, "_nevt"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check_eq({tag, "_evt"}, 32'(obs_q[i]), 32'(exp_q[i]));
        check_eq({tag, "_hold"}, 32'({code_rel, code_ext, code}), 32'({m_crel, m_cext, m_code}));
        check_eq({tag, "_busy"}, 32'(rx_busy), 32'd0);
        if (exp_valid_last) begin
            lat = last_valid_cyc - stop_fall_cyc;
            check_eq({tag, "_lat"}, 32'(lat >= 1 && lat <= LAT_MAX), 32'd1);
        end
        obs_q.delete();
        exp_q.delete();
        exp_valid_last = 0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        bit bp, bs, gl, b2b;
        int half;

        // Reset state
        reset = 1'b0;
        wait_cyc(6);
        check_eq("rst_code", 32'(code), 32'h00);
        check_eq("rst_flags", 32'({code_rel, code_ext}), 32'd0);
        check_eq("rst_strobes", 32'({code_valid, frame_err}), 32'd0);
        check_eq("rst_busy", 32'(rx_busy), 32'd0);
        reset = 1'b1;
        model_reset();
        obs_q.delete();
        wait_cyc(10);

        // 8 us bit period frames: good 0xC1, then the same byte with bad parity
        send_frame(8'hC1, 0, 0, 200, 0);
        compare_events("c1");
        send_frame(8'hC1, 1, 0, 200, 0);
        compare_events("c1_badpar");

        // Release prefix, then extended release with a following plain make
        send_frame(8'hF0, 0, 0, 30, 0);
        send_frame(8'h1C, 0, 0, 30, 0);
        compare_events("rel_1c");
        send_frame(8'hE0, 0, 0, 30, 0);
        send_frame(8'hF0, 0, 0, 30, 0);
        send_frame(8'h75, 0, 0, 30, 0);
        compare_events("extrel_75");
        send_frame(8'h75, 0, 0, 30, 0);
        compare_events("plain_75");

        // Bad stop bit after a pending prefix: prefix must be dropped
        send_frame(8'hE0, 0, 0, 30, 0);
        send_frame(8'h3A, 0, 1, 30, 0);
        send_frame(8'h3A, 0, 0, 30, 0);
        compare_events("badstop");

        // Glitches on ps2clk while idle
        for (int i = 0; i < 4; i++) begin
            ps2clk = 1'b0;
            wait_cyc(3);
            ps2clk = 1'b1;
            wait_cyc(20);
        end
        compare_events("idle_glitch");

        // Glitched partial frame after a prefix, aborted by reset
        send_frame(8'hF0, 0, 0, 30, 0);
        send_partial(8'h55, 3, 30, 1);
        check_eq("mid_busy", 32'(rx_busy), 32'd1);
        reset = 1'b0;
        wait_cyc(4);
        reset = 1'b1;
        model_reset();
        wait_cyc(50);
        compare_events("rst_mid");
        send_frame(8'hC1, 0, 0, 30, 1);
        compare_events("after_rst");

        // Timeout after 4 data bits, with a pending extended prefix
        send_frame(8'hE0, 0, 0, 30, 0);
        send_partial(8'h1C, 4, 30, 0);
        wait_cyc(100);
        check_eq("to_busy", 32'(rx_busy), 32'd1);
        wait_cyc(TO + 50);
        model_err();
        compare_events("timeout");
        send_frame(8'h1C, 0, 0, 30, 0);
        compare_events("after_to");

        // Randomised frames, some back-to-back, some glitched or corrupted
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 7))
                0:       b = 8'hE0;
                1:       b = 8'hF0;
                default: b = 8'($urandom);
            endcase
            bp   = ($urandom_range(0, 7) == 0);
            bs   = ($urandom_range(0, 11) == 0);
            gl   = ($urandom_range(0, 3) == 0);
            b2b  = ($urandom_range(0, 3) == 0);
            half = $urandom_range(16, 40);
            send_frame(b, bp, bs, half, gl);
            if (!b2b || n == 29) compare_events("rnd");
        end

        check_eq("no_overlap", 32'(both_cnt), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
